// File: rtl/fft_pkg.sv
// Shared fixed-point helpers for the FFT datapath: complex packing {re, im}
// and saturation limits for an n-bit two's-complement component.
package fft_pkg;

    localparam int FFT_N = 8;
    localparam int FFT_Q = 6;

    // Sign-extended real field of a value packed as {re[2n-1:n], im[n-1:0]}.
    function automatic logic signed [31:0] cx_re(input logic [63:0] v, input int n);
        logic [63:0] t;
        t = v << (64 - 2 * n);
        return 32'(signed'(t) >>> (64 - n));
    endfunction

    function automatic logic signed [31:0] cx_im(input logic [63:0] v, input int n);
        logic [63:0] t;
        t = v << (64 - n);
        return 32'(signed'(t) >>> (64 - n));
    endfunction

    function automatic logic [63:0] cx_pack(input logic [63:0] re, input logic [63:0] im,
                                            input int n);
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        return ((re & mask) << n) | (im & mask);
    endfunction

    function automatic int sat_max(input int n);
        return (2 ** (n - 1)) - 1;
    endfunction

    function automatic int sat_min(input int n);
        return -(2 ** (n - 1));
    endfunction

endpackage

// File: rtl/butterfly_pipe_cmul.sv
// Two-stage pipelined complex multiply B*W with round-half-up to Q fractional
// bits; a side-band word travels alongside so the caller keeps its operands aligned.
module cmul_pipe #(
    parameter int N  = fft_pkg::FFT_N,
    parameter int Q  = fft_pkg::FFT_Q,
    parameter int XW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                valid_i,
    input  logic [2*N-1:0]      b_i,
    input  logic [2*N-1:0]      w_i,
    input  logic [XW-1:0]       side_i,
    output logic                valid_o,
    output logic signed [N+1:0] p_re_o,
    output logic signed [N+1:0] p_im_o,
    output logic [XW-1:0]       side_o
);
    import fft_pkg::*;

    localparam int PW = 2 * N;
    localparam int SW = 2 * N + 1;
    localparam logic signed [SW-1:0] RND = SW'(2 ** (Q - 1));

    logic signed [N-1:0]  bRe, bIm, wRe, wIm;
    logic signed [PW-1:0] rr_d, ii_d, ri_d, ir_d;
    logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;
    logic                 v1_q, v2_q;
    logic [XW-1:0]        x1_q, x2_q;
    logic signed [N+1:0]  pRe_d, pIm_d, pRe_q, pIm_q;

    always_comb begin
        bRe  = N'(cx_re(64'(b_i), N));
        bIm  = N'(cx_im(64'(b_i), N));
        wRe  = N'(cx_re(64'(w_i), N));
        wIm  = N'(cx_im(64'(w_i), N));
        rr_d = PW'(bRe) * PW'(wRe);
        ii_d = PW'(bIm) * PW'(wIm);
        ri_d = PW'(bRe) * PW'(wIm);
        ir_d = PW'(bIm) * PW'(wRe);
    end

    // The rounded product is narrowed to N+2 bits, the width of the butterfly adder.
    always_comb begin
        pRe_d = (N+2)'((SW'(rr_q) - SW'(ii_q) + RND) >>> Q);
        pIm_d = (N+2)'((SW'(ri_q) + SW'(ir_q) + RND) >>> Q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (en_i) begin
            v1_q <= valid_i;
            v2_q <= v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            rr_q  <= rr_d;
            ii_q  <= ii_d;
            ri_q  <= ri_d;
            ir_q  <= ir_d;
            x1_q  <= side_i;
            pRe_q <= pRe_d;
            pIm_q <= pIm_d;
            x2_q  <= x1_q;
        end
    end

    assign valid_o = v2_q;
    assign p_re_o  = pRe_q;
    assign p_im_o  = pIm_q;
    assign side_o  = x2_q;

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 butterfly (A +/- B*W) with stall backpressure and overflow flags.
// Define BUTTERFLY_SAT_EN to clamp out-of-range components instead of wrapping.
module butterfly_pipe #(
    parameter int N = fft_pkg::FFT_N,
    parameter int Q = fft_pkg::FFT_Q
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] in_a,
    input  logic [2*N-1:0] in_b,
    input  logic [2*N-1:0] in_w,
    input  logic           scale,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_add,
    output logic [2*N-1:0] out_sub,
    output logic           out_ovf,
    output logic           ovf_sticky,
    input  logic           ovf_clr
);
    import fft_pkg::*;

    localparam int XW = 2 * N + 1;
    localparam int SW = N + 2;
    localparam logic signed [SW-1:0] SMAX = SW'(sat_max(N));
    localparam logic signed [SW-1:0] SMIN = SW'(sat_min(N));

    // Returns {overflow, component}; scaling is a floor shift applied before the range check.
    function automatic logic [N:0] fit(input logic signed [SW-1:0] v, input logic sc);
        logic signed [SW-1:0] s;
        logic                 ovf;
        logic [N-1:0]         res;
        s   = sc ? (v >>> 1) : v;
        ovf = (s > SMAX) || (s < SMIN);
`ifdef BUTTERFLY_SAT_EN
        if (s > SMAX) begin
            res = SMAX[N-1:0];
        end else if (s < SMIN) begin
            res = SMIN[N-1:0];
        end else begin
            res = s[N-1:0];
        end
`else
        res = s[N-1:0];
`endif
        return {ovf, res};
    endfunction

    logic                 stall, en;
    logic                 s2Valid;
    logic signed [SW-1:0] pRe, pIm;
    logic [XW-1:0]        s2Side;
    logic signed [SW-1:0] aRe, aIm;
    logic                 s2Scale;
    logic [N:0]           addRe, addIm, subRe, subIm;
    logic [2*N-1:0]       outAdd_d, outSub_d, outAdd_q, outSub_q;
    logic                 outOvf_d, outOvf_q, outValid_q;
    logic                 sticky_d, sticky_q;

    assign stall    = outValid_q && !out_ready;
    assign en       = !stall;
    assign in_ready = en;

    cmul_pipe #(
        .N  (N),
        .Q  (Q),
        .XW (XW)
    ) u_cmul (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en),
        .valid_i (in_valid),
        .b_i     (in_b),
        .w_i     (in_w),
        .side_i  ({scale, in_a}),
        .valid_o (s2Valid),
        .p_re_o  (pRe),
        .p_im_o  (pIm),
        .side_o  (s2Side)
    );

    always_comb begin
        aRe      = SW'(cx_re(64'(s2Side[2*N-1:0]), N));
        aIm      = SW'(cx_im(64'(s2Side[2*N-1:0]), N));
        s2Scale  = s2Side[XW-1];
        addRe    = fit(aRe + pRe, s2Scale);
        addIm    = fit(aIm + pIm, s2Scale);
        subRe    = fit(aRe - pRe, s2Scale);
        subIm    = fit(aIm - pIm, s2Scale);
        outAdd_d = (2*N)'(cx_pack(64'(addRe[N-1:0]), 64'(addIm[N-1:0]), N));
        outSub_d = (2*N)'(cx_pack(64'(subRe[N-1:0]), 64'(subIm[N-1:0]), N));
        outOvf_d = s2Valid && (addRe[N] || addIm[N] || subRe[N] || subIm[N]);
    end

    // A transfer carrying overflow sets the sticky flag even if a clear arrives together.
    always_comb begin
        sticky_d = sticky_q;
        if (outValid_q && out_ready && outOvf_q) begin
            sticky_d = 1'b1;
        end else if (ovf_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outAdd_q   <= '0;
            outSub_q   <= '0;
            outOvf_q   <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            if (en) begin
                outValid_q <= s2Valid;
                outAdd_q   <= outAdd_d;
                outSub_q   <= outSub_d;
                outOvf_q   <= outOvf_d;
            end
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = outValid_q;
    assign out_add    = outAdd_q;
    assign out_sub    = outSub_q;
    assign out_ovf    = outOvf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: doc/butterfly_pipe.md
BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 Parameter N, default 8, width in bits of each real/imag component (two's complement).
REQ-002 Parameter Q, default 6, fractional bits of the fixed-point format (Q < N).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  input sample valid.
REQ-006 in_ready  output  1  block can accept a sample this cycle.
REQ-007 in_a  input  2N  butterfly upper operand {real[2N-1:N], imag[N-1:0]}.
REQ-008 in_b  input  2N  butterfly lower operand, same packing.
REQ-009 in_w  input  2N  twiddle factor, same packing.
REQ-010 scale  input  1  per-sample divide-by-2 of both outputs, sampled with in_valid.
REQ-011 out_valid  output  1  output sample valid.
REQ-012 out_ready  input  1  downstream accepts output.
REQ-013 out_add  output  2N  A + B*W, same packing.
REQ-014 out_sub  output  2N  A - B*W, same packing.
REQ-015 out_ovf  output  1  overflow on any of the four output components of the current output sample.
REQ-016 ovf_sticky  output  1  latched OR of out_ovf over all transferred samples.
REQ-017 ovf_clr  input  1  clears ovf_sticky.

Function
REQ-018 Transfer occurs on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-019 Three-stage pipeline: S1 registers four N x N products; S2 forms P_re=ar... i.e. br*wr-bi*wi and P_im=br*wi+bi*wr at 2N+1 bits, adds 2^(Q-1), arithmetic-shifts right Q; S3 computes A+P and A-P at N+2 bits.
REQ-020 Latency exactly 3 cycles from input transfer to out_valid when out_ready held high; throughput one sample per cycle.
REQ-021 When scale=1, S3 results arithmetic-shift right 1 (floor) before range check.
REQ-022 Result outside [-2^(N-1), 2^(N-1)-1] sets out_ovf for that sample; wrap vs saturate per REQ-030.
REQ-023 Stall: stall = out_valid && !out_ready; all stages freeze while stall=1; in_ready = !stall (combinational from out_ready).
REQ-024 Bubbles propagate; per-stage valid bits; no sample dropped, duplicated or reordered.
REQ-025 Outputs (out_add, out_sub, out_ovf) stay stable while out_valid && !out_ready.
REQ-026 ovf_sticky sets on output transfer with out_ovf=1; ovf_clr clears it next cycle; simultaneous set and clear: set wins.

Reset
REQ-027 rst=1 clears all stage valid bits, out_valid=0, out_ovf=0, ovf_sticky=0, out_add=0, out_sub=0, on the next rising edge.
REQ-028 rst mid-operation discards all in-flight samples; in_ready=1 in the first cycle after reset deasserts.
REQ-029 Data registers other than outputs need not be reset.

Configuration
REQ-030 Macro BUTTERFLY_SAT_EN defined: out-of-range components clamp to 2^(N-1)-1 or -2^(N-1); undefined: low N bits kept (wrap). out_ovf behaviour identical in both builds.

Structure
REQ-031 Shared package fft_pkg holds complex packing helpers (re/im field extraction), and saturation-limit constants derived from N.
REQ-032 One sub-module, cmul_pipe (S1-S2 complex multiply with rounding), instantiated once; add/sub/scale/saturate stay in butterfly_pipe.

Verification (N=8, Q=6, 1.0=64)
REQ-033 a=(32,0), b=(64,0), w=(64,0), scale=0 -> 3 cycles later out_add=(96,0), out_sub=(-32,0), out_ovf=0.
REQ-034 a=(0,0), b=(0,64), w=(0,64) -> out_add=(-64,0), out_sub=(64,0).
REQ-035 a=(100,0), b=(64,0), w=(64,0) -> out_ovf=1, ovf_sticky=1; out_add=(127,0) with BUTTERFLY_SAT_EN, (-92,0) without; out_sub=(36,0).
REQ-036 Same as REQ-033 with scale=1 -> out_add=(48,0), out_sub=(-16,0).
REQ-037 Stream 10 samples, out_ready low for 5 cycles mid-stream -> in_ready low during stall, all 10 outputs in order, unchanged while held.
REQ-038 rst pulse with 3 samples in flight -> out_valid=0 next cycle, no stale output afterwards; ovf_clr with concurrent overflow transfer -> ovf_sticky stays 1.
